// File: rtl/dtof_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dtof_pkg
// Description : Shared constants and types for the dToF histogram/peak chain.
//               NP     - width of one peak (time-of-flight) word
//               PIXELS - pixels per RAM
//               IDXW   - width of a pixel index
// Revision    : 1.0 - initial release
// ============================================================================
package dtof_pkg;

  localparam int NP     = 12;
  localparam int PIXELS = 200;
  localparam int IDXW   = 8;

  typedef logic [NP-1:0] peak_t;

  // Streamer FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    CHECKSUM = 2'd2
  } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/peak_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : peak_result_streamer
// Description : Snapshots the per-pixel peak array on frame_done and streams
//               it one pixel per beat over a valid/ready interface. The
//               shadow copy lets the upstream stage start the next frame at
//               once.
// Ports       : clk         - system clock (posedge)
//               res         - asynchronous active-low reset
//               frame_done  - 1-cycle strobe, peak_in valid this cycle
//               peak_in     - unpacked array of PIXELS peak words
//               ovr_clr     - synchronous clear of the overrun flag
//               out_data    - beat payload
//               out_pixel   - pixel index of the beat
//               out_valid   - beat valid
//               out_ready   - sink ready, beat accepted on valid & ready
//               out_last    - final beat of the frame
//               busy        - high while not IDLE
//               overrun     - sticky, frame_done dropped while busy
// Config      : PEAK_STREAM_CHECKSUM_EN - append one checksum beat
//               (sum mod 2^NP of all pixel words, out_pixel = PIXELS).
// Revision    : 1.0 - initial release
// ============================================================================
module peak_result_streamer #(
  parameter int NP     = 12,
  parameter int PIXELS = 200,
  parameter int IDXW   = 8
) (
  input  logic            clk,
  input  logic            res,
  input  logic            frame_done,
  input  logic [NP-1:0]   peak_in [PIXELS],
  input  logic            ovr_clr,
  output logic [NP-1:0]   out_data,
  output logic [IDXW-1:0] out_pixel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            overrun
);

  import dtof_pkg::*;

  localparam logic [IDXW-1:0] c_idx_last = IDXW'(PIXELS - 1);
`ifdef PEAK_STREAM_CHECKSUM_EN
  localparam logic [IDXW-1:0] c_idx_sum    = IDXW'(PIXELS);
  localparam logic            c_first_last = 1'b0;
`else
  localparam logic            c_first_last = 1'(PIXELS == 1);
`endif

  stream_state_t   r_state;
  logic [IDXW-1:0] r_idx;
  logic [NP-1:0]   r_shadow [PIXELS];
`ifdef PEAK_STREAM_CHECKSUM_EN
  logic [NP-1:0]   r_sum;
  logic [NP-1:0]   w_sum_next;
`endif

  logic            w_hs;
  logic            w_final_hs;
  logic            w_accept;
  logic [IDXW-1:0] w_next_idx;
  logic [NP-1:0]   w_next_word;

  // All control is derived from registered outputs, so out_ready never
  // reaches out_valid/out_data combinationally.
  assign w_hs       = out_valid & out_ready;
  assign w_final_hs = w_hs & out_last;
  // A new frame is taken when idle, or when it lands exactly on the closing
  // handshake of the current frame (back-to-back frames without a bubble).
  assign w_accept   = frame_done & ((r_state == IDLE) | w_final_hs);
  assign w_next_idx = r_idx + 1'b1;
  assign busy       = (r_state != IDLE);

`ifdef PEAK_STREAM_CHECKSUM_EN
  assign w_sum_next = r_sum + out_data;
`endif

  // Shadow read mux for the next beat, compared on the full index width so
  // the index needs no narrowing when PIXELS is not a power of two.
  always_comb begin
    w_next_word = '0;
    for (int i = 0; i < PIXELS; i++) begin
      if (w_next_idx == IDXW'(i)) begin
        w_next_word = r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_shadow  <= '{default: '0};
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pixel <= '0;
      out_last  <= 1'b0;
`ifdef PEAK_STREAM_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else if (w_accept) begin
      r_state   <= STREAM;
      r_idx     <= '0;
      r_shadow  <= peak_in;
      out_valid <= 1'b1;
      out_data  <= peak_in[0];
      out_pixel <= '0;
      out_last  <= c_first_last;
`ifdef PEAK_STREAM_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      case (r_state)
        STREAM: begin
          if (w_hs) begin
`ifdef PEAK_STREAM_CHECKSUM_EN
            r_sum <= w_sum_next;
`endif
            if (r_idx == c_idx_last) begin
`ifdef PEAK_STREAM_CHECKSUM_EN
              r_state   <= CHECKSUM;
              out_data  <= w_sum_next;
              out_pixel <= c_idx_sum;
              out_last  <= 1'b1;
`else
              r_state   <= IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_pixel <= '0;
              out_last  <= 1'b0;
`endif
            end else begin
              r_idx     <= w_next_idx;
              out_data  <= w_next_word;
              out_pixel <= w_next_idx;
`ifdef PEAK_STREAM_CHECKSUM_EN
              out_last  <= 1'b0;
`else
              out_last  <= (w_next_idx == c_idx_last);
`endif
            end
          end
        end
`ifdef PEAK_STREAM_CHECKSUM_EN
        CHECKSUM: begin
          if (w_hs) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pixel <= '0;
            out_last  <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Sticky overrun; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      overrun <= 1'b0;
    end else if (frame_done & (r_state != IDLE) & ~w_final_hs) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peak_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_result_streamer
// Description : Scoreboard bench for peak_result_streamer with PIXELS=4,
//               NP=12. Stimulus pushes expected beats into a queue; a
//               negedge monitor pops and compares every accepted beat and
//               checks that stalled beats stay stable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peak_result_streamer;

  localparam int NP  = 12;
  localparam int PIX = 4;
  localparam int IW  = 8;
`ifdef PEAK_STREAM_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int NBEATS = PIX + (CHK ? 1 : 0);

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          frame_done = 1'b0;
  logic          ovr_clr = 1'b0;
  logic          out_ready = 1'b0;
  logic [NP-1:0] peak_in [PIX];
  logic [NP-1:0] out_data;
  logic [IW-1:0] out_pixel;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          overrun;

  typedef struct packed {
    logic [NP-1:0] data;
    logic [IW-1:0] pix;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  logic [NP-1:0] fa [PIX] = '{12'd10, 12'd20, 12'd30, 12'd40};
  logic [NP-1:0] fb [PIX] = '{12'd1, 12'd2, 12'd3, 12'd4};
  logic [NP-1:0] fo [PIX] = '{12'd5, 12'd6, 12'd7, 12'd8};
  logic [NP-1:0] fc [PIX] = '{12'd4095, 12'd4095, 12'd2, 12'd0};
  logic [3:0]    pat = 4'b1001;

  always #5 clk = ~clk;

  peak_result_streamer #(.NP(NP), .PIXELS(PIX), .IDXW(IW)) dut (
    .clk        (clk),
    .res        (res),
    .frame_done (frame_done),
    .peak_in    (peak_in),
    .ovr_clr    (ovr_clr),
    .out_data   (out_data),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected beats of one frame, checksum accumulated here mod 2^NP.
  task automatic push_frame(input logic [NP-1:0] d [PIX]);
    beat_t         b;
    logic [NP-1:0] s;
    s = '0;
    for (int i = 0; i < PIX; i++) begin
      s      = s + d[i];
      b.data = d[i];
      b.pix  = IW'(i);
      b.last = !CHK && (i == PIX - 1);
      exp_q.push_back(b);
    end
    if (CHK) begin
      b.data = s;
      b.pix  = IW'(PIX);
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Returns at posedge+1 of the edge that sampled frame_done.
  task automatic start_frame(input logic [NP-1:0] d [PIX]);
    @(posedge clk); #1;
    frame_done = 1'b1;
    peak_in    = d;
    push_frame(d);
    @(posedge clk); #1;
    frame_done = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_within_budget", 32'(k < 200), 32'd1);
    check("queue_empty_after_drain", exp_q.size(), 32'd0);
  endtask

  // Monitor: compare every accepted beat, and hold-stability during stalls.
  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    beat_t act;
    beat_t exp;
    act = '{data: out_data, pix: out_pixel, last: out_last};
    if (res) begin
      if (stalled && out_valid) begin
        n_checks++;
        if (act !== held) begin
          n_errors++;
          $display("FAIL stall_hold: got data %0d pix %0d last %0d expected data %0d pix %0d last %0d",
                   act.data, act.pix, act.last, held.data, held.pix, held.last);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat: got data %0d pix %0d expected no beat", act.data, act.pix);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_errors++;
            $display("FAIL beat: got data %0d pix %0d last %0d expected data %0d pix %0d last %0d",
                     act.data, act.pix, act.last, exp.data, exp.pix, exp.last);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = act;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < PIX; i++) peak_in[i] = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_pixel", 32'(out_pixel), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    res = 1'b1;

    // Full-rate stream, one-cycle latency, busy drops after last handshake
    out_ready = 1'b1;
    start_frame(fa);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'd10);
    check("lat_pixel", 32'(out_pixel), 32'd0);
    repeat (NBEATS - 1) @(posedge clk); #1;
    check("busy_before_last_hs", 32'(busy), 32'd1);
    check("last_flag_on_final", 32'(out_last), 32'd1);
    @(posedge clk); #1;
    check("busy_after_last_hs", 32'(busy), 32'd0);
    check("valid_after_last_hs", 32'(out_valid), 32'd0);
    drain();

    // Backpressure with ready pattern 1,0,0,1...
    out_ready = 1'b0;
    start_frame(fa);
    for (int k = 0; k < 60 && (exp_q.size() != 0 || busy); k++) begin
      out_ready = pat[k % 4];
      @(posedge clk); #1;
    end
    drain();

    // Overrun: second frame_done at beat 2 is dropped
    out_ready = 1'b1;
    start_frame(fa);
    repeat (2) @(posedge clk); #1;
    check("ovr_at_pixel2", 32'(out_pixel), 32'd2);
    frame_done = 1'b1;
    peak_in    = fo;
    @(posedge clk); #1;
    frame_done = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    drain();
    check("overrun_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Set wins over simultaneous clear
    out_ready = 1'b0;
    start_frame(fa);
    frame_done = 1'b1;
    ovr_clr    = 1'b1;
    peak_in    = fo;
    @(posedge clk); #1;
    frame_done = 1'b0;
    ovr_clr    = 1'b0;
    check("overrun_set_wins", 32'(overrun), 32'd1);
    drain();
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    check("overrun_cleared2", 32'(overrun), 32'd0);

    // Back-to-back: frame_done on the final handshake is accepted
    out_ready = 1'b1;
    start_frame(fa);
    repeat (NBEATS - 1) @(posedge clk); #1;
    check("b2b_final_last", 32'(out_last), 32'd1);
    frame_done = 1'b1;
    peak_in    = fb;
    push_frame(fb);
    @(posedge clk); #1;
    frame_done = 1'b0;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_data", 32'(out_data), 32'd1);
    check("b2b_pixel", 32'(out_pixel), 32'd0);
    check("b2b_overrun", 32'(overrun), 32'd0);
    drain();

    // Checksum wrap frame (plain data stream when checksum is disabled)
    start_frame(fc);
    drain();

    // Asynchronous reset in the middle of a stalled stream with overrun set
    out_ready = 1'b0;
    start_frame(fa);
    frame_done = 1'b1;
    @(posedge clk); #1;
    frame_done = 1'b0;
    check("pre_reset_overrun", 32'(overrun), 32'd1);
    #2 res = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_pixel", 32'(out_pixel), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    res = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
